// File: rtl/ram_16x8.sv
`default_nettype none
// ============================================================================
// Module      : ram_16x8
// Description : 16x8 program/data RAM with registered read port and a
//               valid/ready sequential loader that fills all locations.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_16x8 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              RAM_in,
    input  logic              RAM_out,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic              prog_done
);

    localparam int              c_DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_PTR_LAST = {ADDR_W{1'b1}};

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_LOAD = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              w_load_wr;
    logic              w_run;
    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [DATA_W-1:0] r_data_out;
    logic              r_out_valid;
    logic              r_prog_ready;
    logic              r_prog_done;

    assign w_run = (r_state == c_S_IDLE);

    // Dropping prog_mode wins over an offered byte in the same cycle.
    always_comb begin
        w_next_state = r_state;
        w_load_wr    = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (prog_mode) w_next_state = c_S_LOAD;
            end
            c_S_LOAD: begin
                if (!prog_mode) begin
                    w_next_state = c_S_IDLE;
                end else if (prog_valid) begin
                    w_load_wr = 1'b1;
                    if (r_ptr == c_PTR_LAST) w_next_state = c_S_DONE;
                end
            end
            c_S_DONE: begin
                if (!prog_mode) w_next_state = c_S_IDLE;
            end
            default: w_next_state = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_S_IDLE;
            r_ptr        <= '0;
            r_prog_ready <= 1'b0;
            r_prog_done  <= 1'b0;
            r_data_out   <= '0;
            r_out_valid  <= 1'b0;
            for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_state      <= w_next_state;
            r_prog_ready <= (w_next_state == c_S_LOAD);
            r_prog_done  <= (w_next_state == c_S_DONE);

            if (w_run && prog_mode) r_ptr <= '0;
            else if (w_load_wr)     r_ptr <= r_ptr + 1'b1;

            // Read samples the array before this edge's write lands.
            r_out_valid <= w_run && RAM_out;
            if (w_run && RAM_out) r_data_out <= r_mem[addr];

            if (w_load_wr)           r_mem[r_ptr] <= prog_data;
            else if (w_run && RAM_in) r_mem[addr]  <= data_in;
        end
    end

    assign data_out   = r_data_out;
    assign out_valid  = r_out_valid;
    assign prog_ready = r_prog_ready;
    assign prog_done  = r_prog_done;

endmodule
`default_nettype wire

// File: tb/tb_ram_16x8.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_16x8
// Description : Self-checking bench for ram_16x8 (vector table + sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_16x8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] addr;
    logic       RAM_in, RAM_out;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       out_valid;
    logic       prog_mode, prog_valid;
    logic [7:0] prog_data;
    logic       prog_ready, prog_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_16x8 #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .RAM_in     (RAM_in),
        .RAM_out    (RAM_out),
        .data_in    (data_in),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .prog_mode  (prog_mode),
        .prog_valid (prog_valid),
        .prog_data  (prog_data),
        .prog_ready (prog_ready),
        .prog_done  (prog_done)
    );

    typedef struct {
        logic       rst;
        logic [3:0] addr;
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic [7:0] exp_dout;
        logic       exp_ov;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs are driven 1 time unit after an edge; outputs checked there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; addr = '0; RAM_in = 1'b0; RAM_out = 1'b0; data_in = '0;
        prog_mode = 1'b0; prog_valid = 1'b0; prog_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic read_chk(input logic [3:0] a, input logic [7:0] exp, input string tag);
        RAM_out = 1'b1; addr = a;
        tick();
        RAM_out = 1'b0;
        chk($sformatf("%s_rd_addr%0d", tag, a), data_out, exp);
        chk($sformatf("%s_ov_addr%0d", tag, a), out_valid, 1'b1);
    endtask

    initial begin
        //            rst  addr   wr    rd    din    exp_dout exp_ov
        vecs[0]  = '{1'b1, 4'h7, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 4'h7, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 4'h7, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 4'h7, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1};
        vecs[4]  = '{1'b0, 4'h3, 1'b1, 1'b0, 8'h5C, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, 4'h3, 1'b0, 1'b1, 8'h00, 8'h5C, 1'b1};
        vecs[6]  = '{1'b0, 4'h3, 1'b1, 1'b1, 8'h77, 8'h5C, 1'b1};
        vecs[7]  = '{1'b0, 4'h3, 1'b0, 1'b1, 8'h00, 8'h77, 1'b1};
        vecs[8]  = '{1'b0, 4'h3, 1'b0, 1'b0, 8'h00, 8'h77, 1'b0};
        vecs[9]  = '{1'b0, 4'hF, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1};
        vecs[10] = '{1'b0, 4'hF, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0};
        vecs[11] = '{1'b0, 4'hF, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b1};

        idle_inputs();
        for (int i = 0; i < 12; i++) begin
            rst = vecs[i].rst; addr = vecs[i].addr; RAM_in = vecs[i].wr;
            RAM_out = vecs[i].rd; data_in = vecs[i].din;
            tick();
            chk($sformatf("vec%0d_dout", i), data_out, vecs[i].exp_dout);
            chk($sformatf("vec%0d_ov", i), out_valid, vecs[i].exp_ov);
            chk($sformatf("vec%0d_ready", i), prog_ready, 1'b0);
            chk($sformatf("vec%0d_done", i), prog_done, 1'b0);
        end
        idle_inputs();

        // Full load 0x10..0x1F with stalls before bytes 4, 9 and 13.
        prog_mode = 1'b1;
        tick();
        chk("load_ready_rise", prog_ready, 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (i == 4 || i == 9 || i == 13) begin
                prog_valid = 1'b0;
                tick();
                chk($sformatf("load_stall%0d_done", i), prog_done, 1'b0);
            end
            prog_valid = 1'b1; prog_data = 8'h10 + 8'(i);
            tick();
            if (i < 15) chk($sformatf("load_byte%0d_done", i), prog_done, 1'b0);
        end
        chk("load_done_set", prog_done, 1'b1);
        chk("load_ready_clr", prog_ready, 1'b0);
        prog_data = 8'hEE;
        tick();
        chk("load_done_hold", prog_done, 1'b1);
        prog_valid = 1'b0; prog_mode = 1'b0;
        tick();
        chk("load_done_fall", prog_done, 1'b0);
        for (int i = 0; i < 16; i++) read_chk(4'(i), 8'h10 + 8'(i), "full");

        // Strobes in LOAD are ignored.
        prog_mode = 1'b1;
        tick();
        RAM_in = 1'b1; RAM_out = 1'b1; addr = 4'h2; data_in = 8'hEE;
        tick();
        chk("ign_ov", out_valid, 1'b0);
        chk("ign_dout_hold", data_out, 8'h1F);
        idle_inputs();
        tick();
        read_chk(4'h2, 8'h12, "ign");

        // Abort after 5 bytes; the byte offered with prog_mode low is dropped.
        do_reset();
        prog_mode = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            prog_valid = 1'b1; prog_data = 8'hA0 + 8'(i);
            tick();
            chk($sformatf("abort_byte%0d_done", i), prog_done, 1'b0);
        end
        prog_mode = 1'b0; prog_data = 8'hBB;
        tick();
        chk("abort_done", prog_done, 1'b0);
        chk("abort_ready", prog_ready, 1'b0);
        prog_valid = 1'b0;
        for (int i = 0; i < 5; i++) read_chk(4'(i), 8'hA0 + 8'(i), "abort");
        read_chk(4'h5, 8'h00, "abort");
        prog_mode = 1'b1;
        tick();
        prog_valid = 1'b1; prog_data = 8'hC1;
        tick();
        idle_inputs();
        tick();
        read_chk(4'h0, 8'hC1, "reenter");
        read_chk(4'h1, 8'hA1, "reenter");

        // Reset in the middle of a load overrides prog_mode.
        prog_mode = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            prog_valid = 1'b1; prog_data = 8'h30 + 8'(i);
            tick();
        end
        rst = 1'b1; prog_data = 8'h99;
        tick();
        chk("rstmid_ready", prog_ready, 1'b0);
        chk("rstmid_done", prog_done, 1'b0);
        chk("rstmid_ov", out_valid, 1'b0);
        chk("rstmid_dout", data_out, 8'h00);
        rst = 1'b0; prog_valid = 1'b0;
        tick();
        chk("rstmid_reenter_ready", prog_ready, 1'b1);
        idle_inputs();
        tick();
        chk("rstmid_exit_ready", prog_ready, 1'b0);
        for (int i = 0; i < 8; i++) read_chk(4'(i), 8'h00, "rstmid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/ram_16x8.md
# ram_16x8

Program/data memory stage fed directly by the memory address register: the 4-bit registered address selects one of 16 bytes, which the block drives toward the bus on request or overwrites from the bus. A load port with a valid/ready handshake and a small state machine fills all 16 locations sequentially before the processor runs. All state, including the memory array, is cleared by reset.

## Interface
Parameters:
- DATA_W, 8, word width in bits
- ADDR_W, 4, address width in bits; depth = 2**ADDR_W (16)

Ports:
- clk  in  1  single system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- addr  in  ADDR_W  address from the address register output
- RAM_in  in  1  write strobe: store data_in at addr
- RAM_out  in  1  read strobe: fetch mem[addr] to data_out
- data_in  in  DATA_W  bus write data
- data_out  out  DATA_W  registered read data
- out_valid  out  1  high for the one cycle in which data_out holds fresh read data
- prog_mode  in  1  level; high requests and holds loader mode
- prog_valid  in  1  loader byte present
- prog_data  in  DATA_W  loader byte
- prog_ready  out  1  block accepts a loader byte this cycle
- prog_done  out  1  all 16 locations loaded; held until prog_mode falls

## Operation
- Loader state machine: IDLE, LOAD, DONE. Load pointer ptr is ADDR_W bits.
- IDLE: run mode. prog_mode=1 -> LOAD with ptr=0.
- LOAD: prog_ready=1. prog_valid=1 -> mem[ptr]<=prog_data, ptr<=ptr+1. When the byte at ptr=15 is accepted -> DONE (ptr wraps to 0, unused). prog_mode=0 -> IDLE in any cycle; bytes already written stay, prog_done stays 0, and the byte offered in that cycle is not written.
- DONE: prog_done=1, prog_ready=0, prog_valid ignored. prog_mode=0 -> IDLE. Re-asserting prog_mode from IDLE restarts at ptr=0.
- Run-mode accesses (IDLE only; RAM_in/RAM_out ignored in LOAD and DONE, out_valid stays 0):
  - RAM_out=1: data_out<=mem[addr], out_valid<=1 next cycle. RAM_out=0: data_out holds its last value, out_valid<=0.
  - RAM_in=1: mem[addr]<=data_in.
  - RAM_in and RAM_out both high on the same address: read returns the old contents (read-before-write); the write still takes effect.
- No width conversion; full DATA_W bits are stored and returned unmodified.

## Timing
- Reset (rst=1 at a rising edge): every mem word = 0x00, data_out=0x00, out_valid=0, prog_ready=0, prog_done=0, state=IDLE, ptr=0. Reset overrides every other input in the same cycle, including in the middle of LOAD.
- Read latency: 1 cycle from the RAM_out edge to data_out/out_valid.
- Write is visible to a read issued at the next edge.
- prog_ready and prog_done are registered from state: prog_ready rises 1 cycle after prog_mode is sampled high in IDLE. prog_done rises 1 cycle after the 16th accepted byte and falls 1 cycle after prog_mode is sampled low.
- The 16-byte load takes at least 16 cycles. Stalls (prog_valid=0) do not advance ptr.

## Test plan
- Reset then read: rst for 2 cycles, then RAM_out=1 with addr=0x7 -> data_out=0x00 and out_valid=1 one cycle later; out_valid=0 before that.
- Full load: prog_mode=1, feed bytes 0x10..0x1F with prog_valid inserting 3 stall cycles -> prog_done=1 after the 16th byte, prog_ready=0; drop prog_mode and read addr 0..15 -> 0x10..0x1F.
- Abort mid-load: load 5 bytes 0xA0..0xA4, drop prog_mode -> addrs 0..4 hold 0xA0..0xA4, addr 5 = 0x00, prog_done never 1; re-enter loader -> first byte lands at addr 0.
- Run write/read: RAM_in with addr=0x3 and data_in=0x5C, next cycle RAM_out on addr=0x3 -> data_out=0x5C; simultaneous RAM_in=0x77 and RAM_out on 0x3 -> data_out=0x5C, then a following read returns 0x77.
- Strobes ignored in loader: during LOAD, RAM_in on addr=0x2 with 0xEE and RAM_out -> mem[2] unchanged, out_valid=0.
- Reset mid-load: rst asserted after 8 loaded bytes -> all outputs at reset values, mem cleared, state IDLE even though prog_mode is still high; loader re-enters LOAD the cycle after rst falls.
